umi_data_fragmenter: RTL

UMI_DATA_FRAGMENTER -- requirements
Module: umi_data_fragmenter

---
 rtl/umi_data_fragmenter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/umi_data_fragmenter.sv
// umi_data_fragmenter
// Splits a wide UMI packet into flits of at most FB bytes each. Only writes,
// posted writes and read responses with ex=0 whose element size fits in FB
// are split; all other packets pass through as a single identical flit.
// Optional build macro: UMI_DATA_FRAGMENTER_ALIGN_EN -- when defined, every
// fragment also stops at an FB-aligned destination address boundary.
//
// Handshake: a transfer happens on a channel in any cycle where valid and
// ready are both high at the rising clock edge. Once valid is raised it
// stays high, and the payload stays stable, until that transfer occurs.
module umi_data_fragmenter #(
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 128,
  parameter int FB = 4
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          umi_in_valid,
  input  logic [CW-1:0] umi_in_cmd,
  input  logic [AW-1:0] umi_in_dstaddr,
  input  logic [AW-1:0] umi_in_srcaddr,
  input  logic [DW-1:0] umi_in_data,
  output logic          umi_in_ready,
  output logic          umi_out_valid,
  output logic [CW-1:0] umi_out_cmd,
  output logic [AW-1:0] umi_out_dstaddr,
  output logic [AW-1:0] umi_out_srcaddr,
  output logic [DW-1:0] umi_out_data,
  input  logic          umi_out_ready,
  output logic          dbg_state
);

  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB) + 1;

  localparam logic [4:0] OP_RESP_READ = 5'h02;
  localparam logic [4:0] OP_WRITE     = 5'h03;
  localparam logic [4:0] OP_POSTED    = 5'h05;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t        state;
  logic          rdy_en;    // keeps ready low while in reset, high from the first edge after
  logic          last_q;    // flit currently on the output is the packet's last
  logic [OW-1:0] off;       // byte offset of the next fragment to build
  logic [CW-1:0] pkt_cmd;
  logic [AW-1:0] pkt_dst;
  logic [AW-1:0] pkt_src;
  logic [DW-1:0] pkt_data;

  logic          accept;
  logic          load;
  logic [CW-1:0] sel_cmd;
  logic [AW-1:0] sel_dst;
  logic [AW-1:0] sel_src;
  logic [DW-1:0] sel_data;
  logic [OW-1:0] sel_off;
  logic [AW-1:0] frag_addr;
  logic [DW-1:0] shifted;
  logic          opc_ok;
  logic          frag_ok;
  logic          last_next;
  logic [CW-1:0] nxt_cmd;
  logic [AW-1:0] nxt_dst;
  logic [DW-1:0] nxt_data;
  logic [OW-1:0] nxt_off;
  int            off_i;
  int            unit;
  int            total;
  int            rem;
  int            chunk;
`ifdef UMI_DATA_FRAGMENTER_ALIGN_EN
  int            mis_base;
  int            mis_frag;
`endif

  // New input is taken when idle, or when the last fragment leaves this cycle.
  assign umi_in_ready = rdy_en & ((state == IDLE) | (last_q & umi_out_ready));
  assign dbg_state    = (state == SEND);

  // Build the next output flit, either fragment 0 of a new input or the
  // next fragment of the held packet.
  always_comb begin
    accept    = umi_in_valid & umi_in_ready;
    load      = accept | ((state == SEND) & umi_out_ready & ~last_q);
    sel_cmd   = accept ? umi_in_cmd     : pkt_cmd;
    sel_dst   = accept ? umi_in_dstaddr : pkt_dst;
    sel_src   = accept ? umi_in_srcaddr : pkt_src;
    sel_data  = accept ? umi_in_data    : pkt_data;
    sel_off   = accept ? '0 : off;
    off_i     = int'(sel_off);
    unit      = 32'd1 << sel_cmd[7:5];
    total     = (int'(sel_cmd[15:8]) + 1) * unit;
    frag_addr = sel_dst + AW'(sel_off);
    opc_ok    = (sel_cmd[4:0] == OP_WRITE) | (sel_cmd[4:0] == OP_POSTED) |
                (sel_cmd[4:0] == OP_RESP_READ);
    nxt_cmd   = sel_cmd;
    nxt_dst   = sel_dst;
    nxt_data  = sel_data;
    shifted   = '0;
    last_next = 1'b1;
`ifdef UMI_DATA_FRAGMENTER_ALIGN_EN
    mis_base  = 32'(sel_dst % AW'(FB));
    mis_frag  = 32'(frag_addr % AW'(FB));
    frag_ok   = opc_ok & ~sel_cmd[24] & (unit <= FB) &
                ((total > FB) | ((mis_base + total) > FB));
    // Stop at the next FB boundary, but never below one element.
    chunk     = FB - mis_frag;
    if (chunk < unit) chunk = unit;
`else
    frag_ok   = opc_ok & ~sel_cmd[24] & (unit <= FB) & (total > FB);
    chunk     = FB;
`endif
    rem = total - off_i;
    if (chunk > rem) chunk = rem;
    if (frag_ok) begin
      last_next       = (off_i + chunk) >= total;
      nxt_cmd[15:8]   = 8'((chunk >> sel_cmd[7:5]) - 1);
      nxt_cmd[22]     = sel_cmd[22] & last_next;
      nxt_dst         = frag_addr;
      shifted         = sel_data >> {sel_off, 3'b000};
      nxt_data        = '0;
      for (int i = 0; i < NB; i++) begin
        if (i < chunk) nxt_data[8*i +: 8] = shifted[8*i +: 8];
      end
    end else begin
      chunk = total;
    end
    nxt_off = OW'(off_i + chunk);
  end

  // IDLE/SEND state machine with registered output flit and held packet.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state           <= IDLE;
      rdy_en          <= 1'b0;
      last_q          <= 1'b0;
      off             <= '0;
      pkt_cmd         <= '0;
      pkt_dst         <= '0;
      pkt_src         <= '0;
      pkt_data        <= '0;
      umi_out_valid   <= 1'b0;
      umi_out_cmd     <= '0;
      umi_out_dstaddr <= '0;
      umi_out_srcaddr <= '0;
      umi_out_data    <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (load) begin
        if (accept) begin
          pkt_cmd  <= umi_in_cmd;
          pkt_dst  <= umi_in_dstaddr;
          pkt_src  <= umi_in_srcaddr;
          pkt_data <= umi_in_data;
        end
        state           <= SEND;
        umi_out_valid   <= 1'b1;
        umi_out_cmd     <= nxt_cmd;
        umi_out_dstaddr <= nxt_dst;
        umi_out_srcaddr <= sel_src;
        umi_out_data    <= nxt_data;
        off             <= nxt_off;
        last_q          <= last_next;
      end else if ((state == SEND) && umi_out_ready) begin
        state         <= IDLE;
        umi_out_valid <= 1'b0;
        off           <= '0;
        last_q        <= 1'b0;
      end
    end
  end

endmodule
